// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio decimator / DC blocker.
package audio_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 12;

    typedef enum logic {
        SEED = 1'b0,
        RUN  = 1'b1
    } dc_state_e;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic int saturate(input int d, input int unsigned w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (d > hi) begin
            return hi;
        end else if (d < lo) begin
            return lo;
        end
        return d;
    endfunction

endpackage

// File: rtl/audio_decim_dcblock_if.sv
// Sample bus between the ADC capture side and the audio conditioner.
// clip_flag exists only when AUDIO_CLIP_DETECT_EN is defined.
interface audio_decim_dcblock_if #(
    parameter int unsigned DATA_WIDTH = audio_pkg::DATA_WIDTH_DEF
);
    logic        [DATA_WIDTH-1:0] ad_data;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] dc_level;
`ifdef AUDIO_CLIP_DETECT_EN
    logic                         clip_flag;

    modport master (output ad_data, in_valid,
                    input  out_data, out_valid, dc_level, clip_flag);
    modport slave  (input  ad_data, in_valid,
                    output out_data, out_valid, dc_level, clip_flag);
`else
    modport master (output ad_data, in_valid,
                    input  out_data, out_valid, dc_level);
    modport slave  (input  ad_data, in_valid,
                    output out_data, out_valid, dc_level);
`endif
endinterface

// File: rtl/dc_tracker.sv
// Leaky DC tracker: seeds on the first average, then subtracts and tracks DC.
// Clip reporting is present only when AUDIO_CLIP_DETECT_EN is defined.
module dc_tracker
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DC_SHIFT   = 10
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic                         avg_valid,
    input  logic signed [DATA_WIDTH-1:0] avg,
`ifdef AUDIO_CLIP_DETECT_EN
    input  logic                         clip_blk,
    output logic                         clip_flag,
`endif
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] dc_level
);

    localparam int unsigned DC_W = DATA_WIDTH + DC_SHIFT + 1;
    localparam int unsigned D_W  = DATA_WIDTH + 1;

    dc_state_e                    state;
    dc_state_e                    state_nxt;
    logic signed [DC_W-1:0]       dc_acc;
    logic signed [DC_W-1:0]       dc_acc_nxt;
    logic signed [D_W-1:0]        d_c;
    int                           sat_c;
    logic signed [DATA_WIDTH-1:0] out_nxt;
    logic                         valid_nxt;
`ifdef AUDIO_CLIP_DETECT_EN
    logic                         sat_hit_c;
    logic                         clip_nxt;
`endif

    // dc_level always equals dc_acc >>> DC_SHIFT, so it serves as the estimate.
    assign d_c = D_W'(avg) - D_W'(dc_level);

    always_comb begin
        sat_c = saturate(32'(d_c), DATA_WIDTH);
    end

`ifdef AUDIO_CLIP_DETECT_EN
    assign sat_hit_c = (sat_c != 32'(d_c));
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            dc_acc    <= '0;
            dc_level  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef AUDIO_CLIP_DETECT_EN
            clip_flag <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            dc_acc    <= dc_acc_nxt;
            dc_level  <= DATA_WIDTH'(dc_acc_nxt >>> DC_SHIFT);
            out_data  <= out_nxt;
            out_valid <= valid_nxt;
`ifdef AUDIO_CLIP_DETECT_EN
            clip_flag <= clip_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        dc_acc_nxt = dc_acc;
        out_nxt    = out_data;
        valid_nxt  = 1'b0;
`ifdef AUDIO_CLIP_DETECT_EN
        clip_nxt   = 1'b0;
`endif
        if (avg_valid) begin
            valid_nxt = 1'b1;
            case (state)
                SEED: begin
                    dc_acc_nxt = DC_W'(avg) <<< DC_SHIFT;
                    out_nxt    = '0;
                    state_nxt  = RUN;
`ifdef AUDIO_CLIP_DETECT_EN
                    clip_nxt   = clip_blk;
`endif
                end
                RUN: begin
                    // Tracker integrates the unsaturated difference.
                    dc_acc_nxt = dc_acc + DC_W'(d_c);
                    out_nxt    = DATA_WIDTH'(sat_c);
`ifdef AUDIO_CLIP_DETECT_EN
                    clip_nxt   = clip_blk | sat_hit_c;
`endif
                end
                default: state_nxt = SEED;
            endcase
        end
    end

endmodule

// File: rtl/audio_decim_dcblock.sv
// ADC code conversion, boxcar decimation and DC removal for the audio path.
// Optional clip detection is enabled by defining AUDIO_CLIP_DETECT_EN.
module audio_decim_dcblock
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DECIM_LOG2 = 8,
    parameter int unsigned DC_SHIFT   = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    audio_decim_dcblock_if.slave  bus
);

    localparam int unsigned ACC_W = DATA_WIDTH + DECIM_LOG2;

    logic signed [DATA_WIDTH-1:0] x;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_sum;
    logic        [DECIM_LOG2-1:0] cnt;
    logic                         last_c;
    logic signed [DATA_WIDTH-1:0] avg;
    logic                         avg_valid;

    // Offset binary to two's complement: flip the MSB.
    assign x       = {~bus.ad_data[DATA_WIDTH-1], bus.ad_data[DATA_WIDTH-2:0]};
    assign acc_sum = acc + ACC_W'(x);
    assign last_c  = bus.in_valid && (cnt == '1);

    // Accumulate-and-dump; the completing sample is folded into the dump.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= last_c;
            if (last_c) begin
                acc <= '0;
                cnt <= '0;
                avg <= DATA_WIDTH'(acc_sum >>> DECIM_LOG2);
            end else if (bus.in_valid) begin
                acc <= acc_sum;
                cnt <= cnt + DECIM_LOG2'(1);
            end
        end
    end

`ifdef AUDIO_CLIP_DETECT_EN
    logic clip_in_c;
    logic clip_sticky;
    logic clip_blk;

    assign clip_in_c = bus.in_valid && ((&bus.ad_data) || ~(|bus.ad_data));

    // Sticky per block; handed to stage 2 alongside the block average.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            clip_sticky <= 1'b0;
            clip_blk    <= 1'b0;
        end else if (last_c) begin
            clip_blk    <= clip_sticky | clip_in_c;
            clip_sticky <= 1'b0;
        end else if (clip_in_c) begin
            clip_sticky <= 1'b1;
        end
    end
`endif

    dc_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .DC_SHIFT   (DC_SHIFT)
    ) u_dc_tracker (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .avg_valid (avg_valid),
        .avg       (avg),
`ifdef AUDIO_CLIP_DETECT_EN
        .clip_blk  (clip_blk),
        .clip_flag (bus.clip_flag),
`endif
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .dc_level  (bus.dc_level)
    );

endmodule

// File: tb/tb_audio_decim_dcblock.sv
// Scoreboard bench for audio_decim_dcblock with a block-level reference model.
module tb_audio_decim_dcblock;

    localparam int unsigned W  = 12;
    localparam int unsigned DL = 2;
    localparam int unsigned DS = 2;
    localparam int          BLK = 1 << DL;

    typedef struct {
        int out_v;
        int dc_v;
        bit clip_v;
        int cyc_v;
    } exp_t;

    logic clk_in;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    int blk_sum;
    int blk_n;
    bit blk_clip;
    bit seeded;
    int dc_acc;

    audio_decim_dcblock_if #(.DATA_WIDTH(W)) bif ();

    audio_decim_dcblock #(
        .DATA_WIDTH (W),
        .DECIM_LOG2 (DL),
        .DC_SHIFT   (DS)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bif)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Floor division by 2^s on plain integers.
    function automatic int fdiv(input int a, input int s);
        int q;
        int m;
        m = 1 << s;
        q = a / m;
        if ((a % m) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int d);
        if (d > 2047) return 2047;
        if (d < -2048) return -2048;
        return d;
    endfunction

    // Reference model: collect a block, average, then seed or track DC.
    task automatic consume(input int code, input int out_cyc);
        int   avg;
        int   d;
        exp_t e;
        blk_sum = blk_sum + (code - 2048);
        blk_n   = blk_n + 1;
        if (code == 0 || code == 4095) blk_clip = 1'b1;
        if (blk_n == BLK) begin
            avg = fdiv(blk_sum, DL);
            if (!seeded) begin
                dc_acc   = avg * (1 << DS);
                e.out_v  = 0;
                e.clip_v = blk_clip;
                seeded   = 1'b1;
            end else begin
                d        = avg - fdiv(dc_acc, DS);
                e.out_v  = clamp(d);
                e.clip_v = blk_clip || (e.out_v != d);
                dc_acc   = dc_acc + d;
            end
            e.dc_v  = fdiv(dc_acc, DS);
            e.cyc_v = out_cyc;
            sb.push_back(e);
            blk_sum  = 0;
            blk_n    = 0;
            blk_clip = 1'b0;
        end
    endtask

    task automatic send(input int code, input bit v);
        @(negedge clk_in);
        bif.ad_data  = 12'(code);
        bif.in_valid = v;
        if (v) consume(code, cyc + 2);
    endtask

    // One bubble cycle before every second sample gives 1 idle cycle in 3.
    task automatic stream(input int code, input int n, input bit bubbles);
        for (int k = 0; k < n; k++) begin
            if (bubbles && (k % 2 == 1)) send(code, 1'b0);
            send(code, 1'b1);
        end
    endtask

    task automatic drain();
        @(negedge clk_in);
        bif.in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_in);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"},  int'(bif.out_data), 0);
        check({tag, "_out_valid"}, int'(bif.out_valid), 0);
        check({tag, "_dc_level"},  int'(bif.dc_level), 0);
`ifdef AUDIO_CLIP_DETECT_EN
        check({tag, "_clip_flag"}, int'(bif.clip_flag), 0);
`endif
    endtask

    // Asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        drain();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        blk_sum  = 0;
        blk_n    = 0;
        blk_clip = 1'b0;
        seeded   = 1'b0;
        dc_acc   = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    // Monitor: pop one expectation per out_valid pulse.
    bit prev_v;
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            prev_v = 1'b0;
        end else begin
            if (bif.out_valid === 1'b1) begin
                check("no_back_to_back", int'(prev_v), 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: actual=out_valid with data %0d required=no output",
                             bif.out_data);
                end else begin
                    e = sb.pop_front();
                    check("latency_cycle", cyc, e.cyc_v);
                    check("out_data", int'(bif.out_data), e.out_v);
                    check("dc_level", int'(bif.dc_level), e.dc_v);
`ifdef AUDIO_CLIP_DETECT_EN
                    check("clip_flag", int'(bif.clip_flag), int'(e.clip_v));
`endif
                end
            end
            prev_v = (bif.out_valid === 1'b1);
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        blk_sum      = 0;
        blk_n        = 0;
        blk_clip     = 1'b0;
        seeded       = 1'b0;
        dc_acc       = 0;
        rst_n        = 1'b0;
        bif.ad_data  = '0;
        bif.in_valid = 1'b0;

        // Reset state before the first clock edge.
        #2 check_reset_outputs("por");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Constant +256 then a step to +512.
        stream(12'h900, 12, 1'b0);
        stream(12'hA00, 12, 1'b0);

        // Same sequence with input bubbles.
        do_reset("rst_b");
        stream(12'h900, 8, 1'b1);
        stream(12'hA00, 12, 1'b1);

        // Seed at full negative scale, then full positive: saturation.
        do_reset("rst_c");
        stream(12'h000, 4, 1'b0);
        stream(12'hFFF, 4, 1'b0);
        drain();

        // Reset mid-block: partial block discarded, tracker re-seeds.
        send(12'h123, 1'b1);
        send(12'h456, 1'b1);
        do_reset("rst_mid");
        stream(12'hB00, 4, 1'b0);
        stream(12'h700, 8, 1'b0);

        // Randomized codes with random bubbles and occasional rail values.
        for (int b = 0; b < 40; b++) begin
            int code;
            for (int k = 0; k < BLK; k++) begin
                case ($urandom_range(0, 7))
                    0:       code = 0;
                    1:       code = 4095;
                    default: code = int'($urandom_range(0, 4095));
                endcase
                if ($urandom_range(0, 3) == 0) send(code, 1'b0);
                send(code, 1'b1);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
